// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction buffer: a small circular FIFO of {PC, Instr, Exc} entries with delay-slot tagging.
// Latency: a word pushed into an empty buffer appears on the decode outputs one cycle later; decode outputs are combinational from the head entry.
// Backpressure: InstrReadyF is low only when the buffer is full and depends on registered occupancy alone; StallD holds the head entry in place.
module if_id_buffer #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        InstrValidF,
   input  logic [31:0] PCF,
   input  logic [31:0] InstrF,
   input  logic        ExcF,
   output logic        InstrReadyF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        BranchD,
   output logic        ValidD,
   output logic [31:0] PCD,
   output logic [31:0] InstrD,
   output logic        ExcD,
   output logic        IsDelaySlotD
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Entry storage, split per field so the head can be read without unpacking.
   logic [31:0]      pcMem    [DEPTH];
   logic [31:0]      instrMem [DEPTH];
   logic             excMem   [DEPTH];

   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [CNT_W-1:0] count;
   // Remembers whether the last instruction to leave decode was a branch/jump.
   logic             prevBranch;

   logic             doPush;
   logic             doPop;

   // Ready and valid derive only from occupancy, so there is no path from StallD to InstrReadyF.
   assign InstrReadyF = (count != FULL_CNT);
   assign ValidD      = (count != '0);

   // Flush cancels both the incoming word and the outgoing pop.
   assign doPush = InstrValidF && InstrReadyF && !FlushD;
   assign doPop  = ValidD && !StallD && !FlushD;

   // Decode outputs read from the head entry, forced to a NOP bubble when empty.
   always_comb begin
      PCD          = 32'h0;
      InstrD       = 32'h0;
      ExcD         = 1'b0;
      IsDelaySlotD = 1'b0;
      if (ValidD) begin
         PCD          = pcMem[rdPtr];
         InstrD       = instrMem[rdPtr];
         ExcD         = excMem[rdPtr];
         IsDelaySlotD = prevBranch;
      end
   end

   // Pointer, occupancy and storage update; reset beats flush, flush beats push/pop/stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr      <= '0;
         wrPtr      <= '0;
         count      <= '0;
         prevBranch <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            pcMem[i]    <= 32'h0;
            instrMem[i] <= 32'h0;
            excMem[i]   <= 1'b0;
         end
      end else if (FlushD) begin
         // Stale entries stay in storage; pointers and count alone hide them.
         rdPtr      <= '0;
         wrPtr      <= '0;
         count      <= '0;
         prevBranch <= 1'b0;
      end else begin
         if (doPush) begin
            pcMem[wrPtr]    <= PCF;
            instrMem[wrPtr] <= InstrF;
            excMem[wrPtr]   <= ExcF;
            wrPtr           <= (wrPtr == LAST_PTR) ? '0 : wrPtr + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr      <= (rdPtr == LAST_PTR) ? '0 : rdPtr + PTR_W'(1);
            prevBranch <= BranchD;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer: reset, flow-through, stall-to-full, push+pop, delay slot, flush, mid-stream reset.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Backpressure: full/empty are observed through InstrReadyF and ValidD only.
module tb_if_id_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        InstrValidF;
   logic [31:0] PCF;
   logic [31:0] InstrF;
   logic        ExcF;
   logic        InstrReadyF;
   logic        StallD;
   logic        FlushD;
   logic        BranchD;
   logic        ValidD;
   logic [31:0] PCD;
   logic [31:0] InstrD;
   logic        ExcD;
   logic        IsDelaySlotD;

   int nVec = 0;
   int nErr = 0;

   // Observed decode-side bundle: {ValidD, InstrReadyF, PCD, InstrD, ExcD, IsDelaySlotD}.
   logic [67:0] obs;
   logic [67:0] exp;
   assign obs = {ValidD, InstrReadyF, PCD, InstrD, ExcD, IsDelaySlotD};

   localparam logic [67:0] EMPTY = {1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};

   if_id_buffer #(.DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .InstrValidF  (InstrValidF),
      .PCF          (PCF),
      .InstrF       (InstrF),
      .ExcF         (ExcF),
      .InstrReadyF  (InstrReadyF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .BranchD      (BranchD),
      .ValidD       (ValidD),
      .PCD          (PCD),
      .InstrD       (InstrD),
      .ExcD         (ExcD),
      .IsDelaySlotD (IsDelaySlotD)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] instr, input logic exc);
      InstrValidF = v;
      PCF         = pc;
      InstrF      = instr;
      ExcF        = exc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      present(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
      StallD = 1'b0; FlushD = 1'b1; BranchD = 1'b1;
      step();
      step();
      rst = 1'b0;
      present(1'b0, 32'h0, 32'h0, 1'b0);
      FlushD = 1'b0; BranchD = 1'b0;
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL reset_state: got %h want %h", obs, exp); end
   endtask

   task automatic test_flow_through();
      present(1'b1, 32'hBFC00000, 32'h24080001, 1'b0);
      StallD = 1'b0;
      step();
      present(1'b0, 32'h0, 32'h0, 1'b0);
      exp = {1'b1, 1'b1, 32'hBFC00000, 32'h24080001, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL flow_head: got %h want %h", obs, exp); end
      step();
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL flow_drained: got %h want %h", obs, exp); end
   endtask

   task automatic test_stall_full();
      StallD = 1'b1;
      present(1'b1, 32'h00400000, 32'h11111111, 1'b0);
      step();
      exp = {1'b1, 1'b1, 32'h00400000, 32'h11111111, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL stall_one: got %h want %h", obs, exp); end
      present(1'b1, 32'h00400004, 32'h22222222, 1'b1);
      step();
      exp = {1'b1, 1'b0, 32'h00400000, 32'h11111111, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL stall_full: got %h want %h", obs, exp); end
      present(1'b1, 32'h00400008, 32'h33333333, 1'b0);
      step();
      exp = {1'b1, 1'b0, 32'h00400000, 32'h11111111, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL stall_reject_third: got %h want %h", obs, exp); end
      present(1'b0, 32'h0, 32'h0, 1'b0);
      StallD = 1'b0;
      step();
      exp = {1'b1, 1'b1, 32'h00400004, 32'h22222222, 1'b1, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL stall_pop_second: got %h want %h", obs, exp); end
      step();
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL stall_drained: got %h want %h", obs, exp); end
   endtask

   task automatic test_back_to_back();
      StallD = 1'b0;
      present(1'b1, 32'h00001000, 32'hA0000000, 1'b0);
      step();
      exp = {1'b1, 1'b1, 32'h00001000, 32'hA0000000, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL b2b_first: got %h want %h", obs, exp); end
      for (int k = 1; k <= 3; k++) begin
         present(1'b1, 32'h00001000 + 32'(4 * k), 32'hA0000000 | 32'(k), 1'b0);
         step();
         exp = {1'b1, 1'b1, 32'h00001000 + 32'(4 * k), 32'hA0000000 | 32'(k), 1'b0, 1'b0}; nVec++;
         if (obs !== exp) begin nErr++; $display("FAIL b2b_k%0d: got %h want %h", k, obs, exp); end
      end
      present(1'b0, 32'h0, 32'h0, 1'b0);
      step();
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL b2b_drained: got %h want %h", obs, exp); end
   endtask

   task automatic test_delay_slot();
      StallD = 1'b1; BranchD = 1'b0;
      present(1'b1, 32'h00000100, 32'h10000002, 1'b0);
      step();
      present(1'b1, 32'h00000104, 32'h24090002, 1'b0);
      step();
      exp = {1'b1, 1'b0, 32'h00000100, 32'h10000002, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL ds_branch_head: got %h want %h", obs, exp); end
      present(1'b0, 32'h0, 32'h0, 1'b0);
      StallD = 1'b0; BranchD = 1'b1;
      step();
      exp = {1'b1, 1'b1, 32'h00000104, 32'h24090002, 1'b0, 1'b1}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL ds_slot_flag: got %h want %h", obs, exp); end
      BranchD = 1'b0;
      present(1'b1, 32'h00000108, 32'h240A0003, 1'b0);
      step();
      exp = {1'b1, 1'b1, 32'h00000108, 32'h240A0003, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL ds_after_slot: got %h want %h", obs, exp); end
      present(1'b0, 32'h0, 32'h0, 1'b0);
      step();
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL ds_drained: got %h want %h", obs, exp); end
   endtask

   task automatic test_flush();
      StallD = 1'b1; BranchD = 1'b1;
      present(1'b1, 32'h00000200, 32'h11110000, 1'b0);
      step();
      present(1'b1, 32'h00000204, 32'h11110004, 1'b0);
      step();
      exp = {1'b1, 1'b0, 32'h00000200, 32'h11110000, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL flush_full_before: got %h want %h", obs, exp); end
      FlushD = 1'b1; StallD = 1'b0;
      present(1'b1, 32'h00000208, 32'h11110008, 1'b0);
      step();
      FlushD = 1'b0; BranchD = 1'b0;
      present(1'b0, 32'h0, 32'h0, 1'b0);
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL flush_empty: got %h want %h", obs, exp); end
      step();
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL flush_no_push: got %h want %h", obs, exp); end
      present(1'b1, 32'h0000020C, 32'h1111000C, 1'b0);
      step();
      present(1'b0, 32'h0, 32'h0, 1'b0);
      exp = {1'b1, 1'b1, 32'h0000020C, 32'h1111000C, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL flush_refill: got %h want %h", obs, exp); end
      step();
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL flush_refill_drain: got %h want %h", obs, exp); end
   endtask

   task automatic test_reset_midstream();
      StallD = 1'b0; BranchD = 1'b0;
      present(1'b1, 32'h00000300, 32'h10000004, 1'b0);
      step();
      BranchD = 1'b1;
      present(1'b1, 32'h00000304, 32'h24100001, 1'b0);
      step();
      StallD = 1'b1; BranchD = 1'b0;
      present(1'b1, 32'h00000308, 32'h24100002, 1'b0);
      step();
      exp = {1'b1, 1'b0, 32'h00000304, 32'h24100001, 1'b0, 1'b1}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL rstmid_before: got %h want %h", obs, exp); end
      rst = 1'b1; StallD = 1'b0; BranchD = 1'b1;
      present(1'b1, 32'h0000030C, 32'h24100003, 1'b1);
      step();
      rst = 1'b0; BranchD = 1'b0;
      present(1'b0, 32'h0, 32'h0, 1'b0);
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL rstmid_after: got %h want %h", obs, exp); end
      present(1'b1, 32'h00000400, 32'h24110001, 1'b0);
      step();
      present(1'b0, 32'h0, 32'h0, 1'b0);
      StallD = 1'b1;
      exp = {1'b1, 1'b1, 32'h00000400, 32'h24110001, 1'b0, 1'b0}; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL rstmid_first_word: got %h want %h", obs, exp); end
      StallD = 1'b0;
      step();
      exp = EMPTY; nVec++;
      if (obs !== exp) begin nErr++; $display("FAIL rstmid_drained: got %h want %h", obs, exp); end
   endtask

   initial begin
      rst = 1'b1;
      present(1'b0, 32'h0, 32'h0, 1'b0);
      StallD = 1'b0; FlushD = 1'b0; BranchD = 1'b0;
      test_reset();
      test_flow_through();
      test_stall_full();
      test_back_to_back();
      test_delay_slot();
      test_flush();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
